// File: rtl/mem_access_unit.sv
// mem_access_unit: fetch/load/store sequencer between the multi-cycle MIPS core and unified RAM.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word requests skip RAM and complete with misalign=1.
module mem_access_unit #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_LATENCY   = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_fetch,
    input  logic                     req_write,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic                     mem_w_en,
    output logic [1:0]               mem_sel,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic [31:0]              IR,
    output logic [31:0]              MDR,
    output logic                     done,
    output logic                     misalign
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]            cnt;
    logic                     fetch_q;
    logic                     write_q;
    logic                     unsigned_q;
    logic                     mis_q;
    logic                     accept;
    logic                     last;
    logic [1:0]               sel_in;
    logic [ADDRESS_WIDTH-1:0] addr_in;
    logic [DATA_WIDTH-1:0]    wdata_in;
    logic                     mis_in;
    logic [7:0]               byte_lane;
    logic [15:0]              half_lane;
    logic [31:0]              ext;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign last      = (state == ACCESS) && (cnt == '0);
    assign done      = (state == DONE);
    assign misalign  = done && mis_q;

    // Gated by RST too, so an abort drops the strobe with no edge needed
    assign mem_w_en = (state == ACCESS) && write_q
                   && (cnt == CNT_INIT) && !RST;

    // Request decode: fetches always read a full word
    always_comb begin
        sel_in   = req_fetch ? 2'b10 : req_size;
        addr_in  = req_addr;
        wdata_in = req_wdata;
        unique case (sel_in)
            2'b00: begin
                wdata_in = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                addr_in[0] = 1'b0;
                wdata_in   = {2{req_wdata[15:0]}};
            end
            default: begin
                addr_in[1:0] = 2'b00;
            end
        endcase
`ifdef MISALIGN_TRAP_EN
        mis_in = ((sel_in == 2'b01) && req_addr[0])
              || (sel_in[1] && (req_addr[1:0] != 2'b00));
`else
        mis_in = 1'b0;
`endif
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = mis_in ? DONE : ACCESS;
            end
            ACCESS: begin
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Lane extraction from the aligned little-endian read word
    always_comb begin
        byte_lane = mem_rdata[{mem_addr[1:0], 3'b000} +: 8];
        half_lane = mem_rdata[{mem_addr[1], 4'b0000} +: 16];
        unique case (mem_sel)
            2'b00:   ext = {{24{~unsigned_q & byte_lane[7]}}, byte_lane};
            2'b01:   ext = {{16{~unsigned_q & half_lane[15]}}, half_lane};
            default: ext = mem_rdata[31:0];
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            fetch_q    <= 1'b0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            mis_q      <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_sel    <= 2'b00;
            IR         <= '0;
            MDR        <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                fetch_q    <= req_fetch;
                write_q    <= req_write && !req_fetch;
                unsigned_q <= req_unsigned;
                mis_q      <= mis_in;
                mem_addr   <= addr_in;
                mem_wdata  <= wdata_in;
                mem_sel    <= sel_in;
                cnt        <= CNT_INIT;
            end else if ((state == ACCESS) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (last && !write_q) begin
                if (fetch_q) IR <= ext;
                else         MDR <= ext;
            end
        end
    end

endmodule
